// File: rtl/dcmac_0_axis_pkt_mon_pkg.sv
// Shared types and constants for the DCMAC AXIS packet monitor checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dcmac_0_axis_pkt_mon_pkg;

    localparam int NUM_SEG   = 12;
    localparam int SEG_BYTES = 16;
    // Width of one per-cycle increment; the largest is a byte sum of 12*16 = 192.
    localparam int INC_W     = 8;

    // Compacted LBUS word: enabled segments are contiguous from segment 0.
    typedef struct packed {
        logic [2:0]                  id;
        logic [NUM_SEG-1:0]          ena;
        logic [NUM_SEG-1:0]          sop;
        logic [NUM_SEG-1:0]          eop;
        logic [NUM_SEG-1:0]          err;
        logic [NUM_SEG-1:0][3:0]     mty;
        logic [NUM_SEG-1:0][127:0]   dat;
    } lbus_pkt_t;

    // Per-cycle increments produced by the framing walk.
    typedef struct packed {
        logic [INC_W-1:0] pkt;
        logic [INC_W-1:0] bytes;
        logic [INC_W-1:0] err_pkt;
        logic [INC_W-1:0] sop_err;
        logic [INC_W-1:0] eop_err;
        logic [INC_W-1:0] ena_gap;
        logic [INC_W-1:0] mty_err;
        logic [INC_W-1:0] oversize;
    } seg_stats_t;

    // Number of set bits in a per-segment flag vector.
    function automatic logic [INC_W-1:0] popcnt(input logic [NUM_SEG-1:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            n = n + INC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dcmac_0_axis_pkt_mon_stat_ctr.sv
// One statistics counter: accumulates increments, snapshots and clears on tick.
// Latency: snapshot is visible the cycle after tick and includes that cycle's increment.
// Backpressure: none; one increment is absorbed every cycle.
module dcmac_0_axis_pkt_mon_stat_ctr #(
    parameter int CNT_W = 48,
    parameter int INC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] sum;

    // Wraps modulo 2^CNT_W by construction.
    assign sum = run + CNT_W'(inc);

    // Running total; on tick the total including this cycle's increment is published and the total restarts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= '0;
            cnt <= '0;
        end else if (tick) begin
            cnt <= sum;
            run <= '0;
        end else begin
            run <= sum;
        end
    end

endmodule

// File: rtl/dcmac_0_axis_pkt_mon_seg_check.sv
// SOP/EOP framing checker and interval statistics for compacted 12-segment LBUS words; oversize check under DCMAC_0_PKT_MON_OVERSIZE_CHK_EN.
// Latency: 2 cycles from i_pkt to the running counters and o_in_pkt; snapshot one cycle after i_tick.
// Backpressure: none; a word is accepted every cycle and ena=0 marks an empty cycle.
module dcmac_0_axis_pkt_mon_seg_check
    import dcmac_0_axis_pkt_mon_pkg::*;
#(
    parameter int CNT_W       = 48,
    parameter int MAX_PKT_LEN = 9600
) (
    input  logic             clk,
    input  logic             rst,
    input  lbus_pkt_t        i_pkt,
    input  logic             i_tick,
    output logic             o_stat_vld,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_byte_cnt,
    output logic [CNT_W-1:0] o_err_pkt_cnt,
    output logic [CNT_W-1:0] o_sop_err_cnt,
    output logic [CNT_W-1:0] o_eop_err_cnt,
    output logic [CNT_W-1:0] o_ena_gap_cnt,
    output logic [CNT_W-1:0] o_mty_err_cnt,
    output logic [CNT_W-1:0] o_oversize_cnt,
    output logic             o_in_pkt
);

    // ---------------- stage 1: per-segment decode ----------------
    logic [NUM_SEG-1:0]      d_mty_err;
    logic [NUM_SEG-1:0][4:0] d_bytes;

    logic [NUM_SEG-1:0]      s1_v;
    logic [NUM_SEG-1:0]      s1_sop;
    logic [NUM_SEG-1:0]      s1_eop;
    logic [NUM_SEG-1:0]      s1_err;
    logic [NUM_SEG-1:0]      s1_mty_err;
    logic [NUM_SEG-1:0][4:0] s1_bytes;
    logic                    s1_gap;

    // id and dat carry no framing information.
    logic unused_pkt_fields;
    assign unused_pkt_fields = ^{i_pkt.id, i_pkt.dat};

    // Byte count per segment (mty only trims the EOP segment) and mty misuse on non-EOP segments.
    always_comb begin
        d_bytes   = '0;
        d_mty_err = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (i_pkt.ena[s]) begin
                d_bytes[s]   = i_pkt.eop[s] ? (5'(SEG_BYTES) - {1'b0, i_pkt.mty[s]}) : 5'(SEG_BYTES);
                d_mty_err[s] = !i_pkt.eop[s] && (i_pkt.mty[s] != 4'd0);
            end
        end
    end

    // Register the decoded word; framing flags are qualified by ena, and a non-contiguous ena is a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= '0;
            s1_sop     <= '0;
            s1_eop     <= '0;
            s1_err     <= '0;
            s1_mty_err <= '0;
            s1_bytes   <= '0;
            s1_gap     <= 1'b0;
        end else begin
            s1_v       <= i_pkt.ena;
            s1_sop     <= i_pkt.sop & i_pkt.ena;
            s1_eop     <= i_pkt.eop & i_pkt.ena;
            s1_err     <= i_pkt.err & i_pkt.ena;
            s1_mty_err <= d_mty_err;
            s1_bytes   <= d_bytes;
            s1_gap     <= (i_pkt.ena & (i_pkt.ena + 12'd1)) != 12'd0;
        end
    end

    // ---------------- stage 2: framing walk ----------------
    logic       in_pkt;
    logic       walk_in_pkt;
    seg_stats_t inc;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
    logic [15:0] pkt_len;
    logic [15:0] walk_len;
    logic [16:0] len_sum;
`endif

    // Walk valid segments in index order from the registered framing state, collecting this cycle's increments.
    always_comb begin
        inc         = '0;
        walk_in_pkt = in_pkt;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
        walk_len    = pkt_len;
        len_sum     = '0;
`endif
        for (int s = 0; s < NUM_SEG; s++) begin
            if (s1_v[s]) begin
                inc.bytes = inc.bytes + INC_W'(s1_bytes[s]);
                if (s1_sop[s]) begin
                    // SOP inside a packet abandons it and starts a new one.
                    if (walk_in_pkt) begin
                        inc.sop_err = inc.sop_err + INC_W'(1);
                    end
                    walk_in_pkt = 1'b1;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
                    walk_len    = '0;
`endif
                end
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
                if (walk_in_pkt) begin
                    len_sum  = {1'b0, walk_len} + 17'(s1_bytes[s]);
                    walk_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
                end
`endif
                if (s1_eop[s]) begin
                    if (walk_in_pkt) begin
                        inc.pkt     = inc.pkt + INC_W'(1);
                        inc.err_pkt = inc.err_pkt + INC_W'(s1_err[s]);
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
                        if (walk_len > 16'(MAX_PKT_LEN)) begin
                            inc.oversize = inc.oversize + INC_W'(1);
                        end
`endif
                        walk_in_pkt = 1'b0;
                    end else begin
                        inc.eop_err = inc.eop_err + INC_W'(1);
                    end
                end
            end
        end
        inc.ena_gap = INC_W'(s1_gap);
        inc.mty_err = popcnt(s1_mty_err);
    end

    // Framing state (and packet length when enabled) carried across words; reset abandons any open packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt  <= 1'b0;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
            pkt_len <= '0;
`endif
        end else begin
            in_pkt  <= walk_in_pkt;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
            pkt_len <= walk_len;
`endif
        end
    end

    assign o_in_pkt = in_pkt;

    // Snapshot strobe follows the tick by one cycle, aligned with the counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_vld <= 1'b0;
        end else begin
            o_stat_vld <= i_tick;
        end
    end

    // ---------------- statistics counters ----------------
    localparam int NUM_CTR = 7;
    logic [NUM_CTR-1:0][INC_W-1:0] ctr_inc;
    logic [NUM_CTR-1:0][CNT_W-1:0] ctr_cnt;

    assign ctr_inc = {inc.mty_err, inc.ena_gap, inc.eop_err, inc.sop_err,
                      inc.err_pkt, inc.bytes, inc.pkt};

    for (genvar c = 0; c < NUM_CTR; c++) begin : g_ctr
        dcmac_0_axis_pkt_mon_stat_ctr #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .inc  (ctr_inc[c]),
            .tick (i_tick),
            .cnt  (ctr_cnt[c])
        );
    end

    assign o_pkt_cnt     = ctr_cnt[0];
    assign o_byte_cnt    = ctr_cnt[1];
    assign o_err_pkt_cnt = ctr_cnt[2];
    assign o_sop_err_cnt = ctr_cnt[3];
    assign o_eop_err_cnt = ctr_cnt[4];
    assign o_ena_gap_cnt = ctr_cnt[5];
    assign o_mty_err_cnt = ctr_cnt[6];

`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
    dcmac_0_axis_pkt_mon_stat_ctr #(
        .CNT_W (CNT_W),
        .INC_W (INC_W)
    ) u_oversize_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc.oversize),
        .tick (i_tick),
        .cnt  (o_oversize_cnt)
    );
`else
    // Without length tracking there is nothing to count.
    assign o_oversize_cnt = '0;
    logic unused_oversize;
    assign unused_oversize = ^{inc.oversize, (MAX_PKT_LEN != 0)};
`endif

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_seg_check.sv
`timescale 1ns/1ps
module tb_dcmac_0_axis_pkt_mon_seg_check;
    import dcmac_0_axis_pkt_mon_pkg::*;

    localparam int CNT_W = 48;
`ifdef DCMAC_0_PKT_MON_OVERSIZE_CHK_EN
    localparam int OVS_EXP = 1;
`else
    localparam int OVS_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    lbus_pkt_t        i_pkt;
    logic             i_tick;
    logic             o_stat_vld;
    logic [CNT_W-1:0] o_pkt_cnt, o_byte_cnt, o_err_pkt_cnt, o_sop_err_cnt;
    logic [CNT_W-1:0] o_eop_err_cnt, o_ena_gap_cnt, o_mty_err_cnt, o_oversize_cnt;
    logic             o_in_pkt;

    always #5 clk = ~clk;

    dcmac_0_axis_pkt_mon_seg_check #(.CNT_W(CNT_W), .MAX_PKT_LEN(9600)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pkt          (i_pkt),
        .i_tick         (i_tick),
        .o_stat_vld     (o_stat_vld),
        .o_pkt_cnt      (o_pkt_cnt),
        .o_byte_cnt     (o_byte_cnt),
        .o_err_pkt_cnt  (o_err_pkt_cnt),
        .o_sop_err_cnt  (o_sop_err_cnt),
        .o_eop_err_cnt  (o_eop_err_cnt),
        .o_ena_gap_cnt  (o_ena_gap_cnt),
        .o_mty_err_cnt  (o_mty_err_cnt),
        .o_oversize_cnt (o_oversize_cnt),
        .o_in_pkt       (o_in_pkt)
    );

    typedef struct packed {
        logic [CNT_W-1:0] pkt, bytes, err_pkt, sop_err, eop_err, gap, mty, ovs;
    } snap_t;

    snap_t sb[$];
    snap_t exp_s;
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic snap_t mks(input int pkt, input int bytes, input int err, input int sop,
                                  input int eop, input int gap, input int mty, input int ovs);
        snap_t s;
        s.pkt = CNT_W'(pkt);     s.bytes = CNT_W'(bytes); s.err_pkt = CNT_W'(err);
        s.sop_err = CNT_W'(sop); s.eop_err = CNT_W'(eop); s.gap = CNT_W'(gap);
        s.mty = CNT_W'(mty);     s.ovs = CNT_W'(ovs);
        return s;
    endfunction

    function automatic lbus_pkt_t mk(input logic [11:0] ena, input logic [11:0] sop,
                                     input logic [11:0] eop, input logic [11:0] err);
        lbus_pkt_t p;
        p     = '0;
        p.id  = 3'd5;
        p.ena = ena; p.sop = sop; p.eop = eop; p.err = err;
        for (int i = 0; i < NUM_SEG; i++) p.dat[i] = {$urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    // Monitor: every snapshot pulse is matched against the next expected snapshot.
    always @(negedge clk) begin
        if (o_stat_vld === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_snapshot: o_stat_vld=1 with no tick outstanding, pkt=%0d", o_pkt_cnt);
            end else begin
                exp_s = sb.pop_front();
                check("snap_pkt",      o_pkt_cnt,      exp_s.pkt);
                check("snap_byte",     o_byte_cnt,     exp_s.bytes);
                check("snap_err_pkt",  o_err_pkt_cnt,  exp_s.err_pkt);
                check("snap_sop_err",  o_sop_err_cnt,  exp_s.sop_err);
                check("snap_eop_err",  o_eop_err_cnt,  exp_s.eop_err);
                check("snap_ena_gap",  o_ena_gap_cnt,  exp_s.gap);
                check("snap_mty_err",  o_mty_err_cnt,  exp_s.mty);
                check("snap_oversize", o_oversize_cnt, exp_s.ovs);
            end
        end
    end

    task automatic cyc(input lbus_pkt_t p, input logic t);
        i_pkt  = p;
        i_tick = t;
        @(posedge clk);
        #1;
    endtask

    // Drain the pipeline, then tick once with the expected snapshot queued.
    task automatic tick_snap(input snap_t e);
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        sb.push_back(e);
        cyc('0, 1'b1);
        cyc('0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lbus_pkt_t p;
        rst    = 1'b1;
        i_pkt  = '0;
        i_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_stat_vld", CNT_W'(o_stat_vld), 0);
        check("rst_in_pkt",   CNT_W'(o_in_pkt),   0);
        check("rst_pkt",      o_pkt_cnt,      0);
        check("rst_byte",     o_byte_cnt,     0);
        check("rst_sop_err",  o_sop_err_cnt,  0);
        check("rst_oversize", o_oversize_cnt, 0);

        // Single-segment packet, 16-4 = 12 bytes
        p = mk(12'h001, 12'h001, 12'h001, 12'h000);
        p.mty[0] = 4'd4;
        cyc(p, 1'b0);
        tick_snap(mks(1, 12, 0, 0, 0, 0, 0, 0));

        // Packet over three full words: 3*192 = 576 bytes
        cyc(mk(12'hFFF, 12'h001, 12'h000, 12'h000), 1'b0);
        cyc(mk(12'hFFF, 12'h000, 12'h000, 12'h000), 1'b0);
        check("in_pkt_after_sop_word", CNT_W'(o_in_pkt), 1);
        cyc(mk(12'hFFF, 12'h000, 12'h800, 12'h000), 1'b0);
        check("in_pkt_after_mid_word", CNT_W'(o_in_pkt), 1);
        cyc('0, 1'b0);
        check("in_pkt_after_eop_word", CNT_W'(o_in_pkt), 0);
        tick_snap(mks(1, 576, 0, 0, 0, 0, 0, 0));

        // Three packets in one word, last errored: seg0 S/E, seg1 S, seg2 E, seg3 S/E err
        cyc(mk(12'h00F, 12'h00B, 12'h00D, 12'h008), 1'b0);
        tick_snap(mks(3, 64, 1, 0, 0, 0, 0, 0));

        // SOP while in packet: restart, then EOP closes one packet
        cyc(mk(12'h001, 12'h001, 12'h000, 12'h000), 1'b0);
        cyc(mk(12'h001, 12'h001, 12'h001, 12'h000), 1'b0);
        tick_snap(mks(1, 32, 0, 1, 0, 0, 0, 0));

        // Lone EOP while idle
        cyc(mk(12'h001, 12'h000, 12'h001, 12'h000), 1'b0);
        tick_snap(mks(0, 16, 0, 0, 1, 0, 0, 0));

        // Non-contiguous ena: gap counted, seg0 SOP and seg2 EOP still framed
        cyc(mk(12'h005, 12'h001, 12'h004, 12'h000), 1'b0);
        tick_snap(mks(1, 32, 0, 0, 0, 1, 0, 0));

        // mty on a non-EOP segment: 16 + (16-2) = 30 bytes, one mty error
        p = mk(12'h003, 12'h001, 12'h002, 12'h000);
        p.mty[0] = 4'd3;
        p.mty[1] = 4'd2;
        cyc(p, 1'b0);
        tick_snap(mks(1, 30, 0, 0, 0, 0, 1, 0));

        // Tick coincident with the stage-2 update of two packets, then a back-to-back tick
        cyc(mk(12'h003, 12'h003, 12'h003, 12'h000), 1'b0);
        sb.push_back(mks(2, 32, 0, 0, 0, 0, 0, 0));
        cyc('0, 1'b1);
        sb.push_back(mks(0, 0, 0, 0, 0, 0, 0, 0));
        cyc('0, 1'b1);
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        // Reset mid-packet abandons it with no error and clears the running counters
        cyc(mk(12'h001, 12'h001, 12'h000, 12'h000), 1'b0);
        cyc('0, 1'b0);
        check("in_pkt_before_reset", CNT_W'(o_in_pkt), 1);
        rst = 1'b1;
        cyc('0, 1'b0);
        rst = 1'b0;
        check("in_pkt_after_reset", CNT_W'(o_in_pkt), 0);
        tick_snap(mks(0, 0, 0, 0, 0, 0, 0, 0));

        // 9601-byte packet: 50 full words plus one 1-byte EOP segment
        cyc(mk(12'hFFF, 12'h001, 12'h000, 12'h000), 1'b0);
        repeat (49) cyc(mk(12'hFFF, 12'h000, 12'h000, 12'h000), 1'b0);
        p = mk(12'h001, 12'h000, 12'h001, 12'h000);
        p.mty[0] = 4'd15;
        cyc(p, 1'b0);
        tick_snap(mks(1, 9601, 0, 0, 0, 0, 0, OVS_EXP));

        // 9600-byte packet: exactly 50 full words, not oversize
        cyc(mk(12'hFFF, 12'h001, 12'h000, 12'h000), 1'b0);
        repeat (48) cyc(mk(12'hFFF, 12'h000, 12'h000, 12'h000), 1'b0);
        cyc(mk(12'hFFF, 12'h000, 12'h800, 12'h000), 1'b0);
        tick_snap(mks(1, 9600, 0, 0, 0, 0, 0, 0));

        repeat (5) cyc('0, 1'b0);
        check("snapshots_outstanding", CNT_W'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
